// File: rtl/jkff_bank_seq.sv
`default_nettype none
// ============================================================================
// Module   : jkff_bank_seq
// Purpose  : Command-driven sequencer for a bank of external JK flip-flops.
//            Accepts SET/CLR/TOGGLE/HOLD commands with a bit mask and repeat
//            count, drives the bank J/K vectors for that many clocks, tracks
//            the expected bank state and checks the bank Q against it.
// Revision : 1.0 - initial release
// ============================================================================
module jkff_bank_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_reps,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] exp_q
);

  // Opcode encoding of cmd_op
  localparam logic [1:0] c_OP_HOLD   = 2'b00;
  localparam logic [1:0] c_OP_SET    = 2'b01;
  localparam logic [1:0] c_OP_CLR    = 2'b10;
  localparam logic [1:0] c_OP_TOGGLE = 2'b11;

  localparam logic [CNT_W-1:0] c_REM_ZERO = '0;
  localparam logic [CNT_W-1:0] c_REM_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Registered state
  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_mask;
  logic [CNT_W-1:0] r_rem;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] r_exp;
  logic             r_done;
  logic             r_err;

  // Next-state values
  state_t           w_state_nxt;
  logic [1:0]       w_op_nxt;
  logic [WIDTH-1:0] w_mask_nxt;
  logic [CNT_W-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_j_nxt;
  logic [WIDTH-1:0] w_k_nxt;
  logic [WIDTH-1:0] w_exp_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_accept;

  // J drive for an op: only SET and TOGGLE raise J, and only on masked bits.
  function automatic logic [WIDTH-1:0] f_j(input logic [1:0] op, input logic [WIDTH-1:0] mask);
    f_j = ((op == c_OP_SET) || (op == c_OP_TOGGLE)) ? mask : '0;
  endfunction

  // K drive for an op: only CLR and TOGGLE raise K, and only on masked bits.
  function automatic logic [WIDTH-1:0] f_k(input logic [1:0] op, input logic [WIDTH-1:0] mask);
    f_k = ((op == c_OP_CLR) || (op == c_OP_TOGGLE)) ? mask : '0;
  endfunction

  // Reference model: the same update a JK flop performs for the given drive.
  function automatic logic [WIDTH-1:0] f_model(input logic [1:0] op,
                                               input logic [WIDTH-1:0] mask,
                                               input logic [WIDTH-1:0] cur);
    case (op)
      c_OP_SET:    f_model = cur | mask;
      c_OP_CLR:    f_model = cur & ~mask;
      c_OP_TOGGLE: f_model = cur ^ mask;
      default:     f_model = cur;
    endcase
  endfunction

  assign w_accept = cmd_valid && (r_state == ST_IDLE);

  // Next-state logic: handshake, apply sequencing, final check.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_mask_nxt  = r_mask;
    w_rem_nxt   = r_rem;
    w_j_nxt     = '0;
    w_k_nxt     = '0;
    w_exp_nxt   = r_exp;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_op_nxt   = cmd_op;
          w_mask_nxt = cmd_mask;
          w_rem_nxt  = cmd_reps;
          w_exp_nxt  = q;
          w_err_nxt  = 1'b0;
          if (cmd_reps != c_REM_ZERO) begin
            // J/K are registered, so they must be loaded at the accept edge
            // to be valid for the whole first APPLY cycle.
            w_state_nxt = ST_APPLY;
            w_j_nxt     = f_j(cmd_op, cmd_mask);
            w_k_nxt     = f_k(cmd_op, cmd_mask);
          end else begin
            w_state_nxt = ST_CHECK;
          end
        end
      end

      ST_APPLY: begin
        // The bank applies the current J/K at this edge; mirror it.
        w_exp_nxt = f_model(r_op, r_mask, r_exp);
        w_rem_nxt = r_rem - c_REM_ONE;
        if (r_rem <= c_REM_ONE) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_j_nxt = f_j(r_op, r_mask);
          w_k_nxt = f_k(r_op, r_mask);
        end
      end

      ST_CHECK: begin
        w_err_nxt   = (q != r_exp);
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset discards any partial command.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= c_OP_HOLD;
      r_mask  <= '0;
      r_rem   <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_exp   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_mask  <= w_mask_nxt;
      r_rem   <= w_rem_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
      r_exp   <= w_exp_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_APPLY) || (r_state == ST_CHECK);
  assign j         = r_j;
  assign k         = r_k;
  assign done      = r_done;
  assign err       = r_err;
  assign exp_q     = r_exp;

endmodule
`default_nettype wire

// File: tb/tb_jkff_bank_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jkff_bank_seq
// Purpose  : Directed self-checking bench for jkff_bank_seq with a behavioural
//            JK flop bank and a stuck-at-0 fault overlay on the bank outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jkff_bank_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [3:0] cmd_reps;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] exp_q;

  logic [3:0] bank;
  logic [3:0] stuck0;
  int         checks = 0;
  int         errors = 0;
  int         accepts = 0;
  int         done_seen = 0;

  jkff_bank_seq #(.WIDTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_reps(cmd_reps),
    .j(j), .k(k), .q(q), .busy(busy), .done(done), .err(err), .exp_q(exp_q)
  );

  always #5 clk = ~clk;

  // Behavioural JK bank: J only sets, K only clears, both toggle.
  always @(posedge clk) begin
    if (rst) bank <= 4'b0000;
    else     bank <= (bank & ~k) | (~bank & j) | (bank & j & ~k);
  end
  assign q = bank & ~stuck0;

  // Handshake and done-pulse observers
  always @(posedge clk) begin
    if (!rst && cmd_valid && cmd_ready) accepts++;
    if (done) done_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] mask, input logic [3:0] reps);
    cmd_op = op; cmd_mask = mask; cmd_reps = reps; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++; if (j !== 4'b0000) begin errors++; $display("FAIL reset_j got=%b exp=0000", j); end
    checks++; if (k !== 4'b0000) begin errors++; $display("FAIL reset_k got=%b exp=0000", k); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (exp_q !== 4'b0000) begin errors++; $display("FAIL reset_expq got=%b exp=0000", exp_q); end
  endtask

  // SET 0101 x1 from 0000
  task automatic test_set();
    issue(2'b01, 4'b0101, 4'd1);
    checks++; if (j !== 4'b0101 || k !== 4'b0000 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL set_c1 j=%b k=%b busy=%b rdy=%b exp j=0101 k=0000 busy=1 rdy=0", j, k, busy, cmd_ready); end
    step();
    checks++; if (j !== 4'b0000 || k !== 4'b0000 || done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL set_c2 j=%b k=%b done=%b busy=%b exp j=0 k=0 done=0 busy=1", j, k, done, busy); end
    step();
    checks++; if (done !== 1'b1 || cmd_ready !== 1'b1 || exp_q !== 4'b0101 || err !== 1'b0 || q !== 4'b0101) begin
      errors++; $display("FAIL set_c3 done=%b rdy=%b expq=%b err=%b q=%b exp done=1 rdy=1 expq=0101 err=0 q=0101", done, cmd_ready, exp_q, err, q); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL set_done_pulse got=%b exp=0", done); end
  endtask

  // TOGGLE 1111 x3 from 0101
  task automatic test_toggle();
    issue(2'b11, 4'b1111, 4'd3);
    for (int c = 1; c <= 3; c++) begin
      checks++; if (j !== 4'b1111 || k !== 4'b1111 || busy !== 1'b1) begin
        errors++; $display("FAIL tog_apply c%0d j=%b k=%b busy=%b exp j=1111 k=1111 busy=1", c, j, k, busy); end
      step();
    end
    checks++; if (j !== 4'b0000 || k !== 4'b0000 || done !== 1'b0) begin
      errors++; $display("FAIL tog_check j=%b k=%b done=%b exp j=0 k=0 done=0", j, k, done); end
    step();
    checks++; if (done !== 1'b1 || exp_q !== 4'b1010 || q !== 4'b1010 || err !== 1'b0) begin
      errors++; $display("FAIL tog_c5 done=%b expq=%b q=%b err=%b exp done=1 expq=1010 q=1010 err=0", done, exp_q, q, err); end
    step();
  endtask

  // CLR 1000 x2 then HOLD 1111 x0 accepted at the edge ending the done cycle
  task automatic test_clr_hold();
    issue(2'b10, 4'b1000, 4'd2);
    for (int c = 1; c <= 2; c++) begin
      checks++; if (j !== 4'b0000 || k !== 4'b1000) begin
        errors++; $display("FAIL clr_apply c%0d j=%b k=%b exp j=0000 k=1000", c, j, k); end
      step();
    end
    step();
    checks++; if (done !== 1'b1 || exp_q !== 4'b0010 || err !== 1'b0) begin
      errors++; $display("FAIL clr_done done=%b expq=%b err=%b exp done=1 expq=0010 err=0", done, exp_q, err); end
    issue(2'b00, 4'b1111, 4'd0);
    checks++; if (j !== 4'b0000 || k !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL hold_c1 j=%b k=%b busy=%b done=%b exp j=0 k=0 busy=1 done=0", j, k, busy, done); end
    step();
    checks++; if (done !== 1'b1 || err !== 1'b0 || exp_q !== 4'b0010 || j !== 4'b0000 || k !== 4'b0000) begin
      errors++; $display("FAIL hold_c2 done=%b err=%b expq=%b j=%b k=%b exp done=1 err=0 expq=0010 j=0 k=0", done, err, exp_q, j, k); end
    step();
  endtask

  // Bit0 stuck at 0, SET 0001 x1 from 0010 -> mismatch, then cleared by next command
  task automatic test_fault();
    stuck0 = 4'b0001;
    issue(2'b01, 4'b0001, 4'd1);
    step();
    step();
    checks++; if (done !== 1'b1 || err !== 1'b1 || exp_q !== 4'b0011) begin
      errors++; $display("FAIL fault_detect done=%b err=%b expq=%b exp done=1 err=1 expq=0011", done, err, exp_q); end
    step(); step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL fault_sticky got=%b exp=1", err); end
    stuck0 = 4'b0000;
    issue(2'b00, 4'b0000, 4'd0);
    checks++; if (err !== 1'b0 || exp_q !== 4'b0011) begin
      errors++; $display("FAIL fault_clear err=%b expq=%b exp err=0 expq=0011", err, exp_q); end
    step();
    checks++; if (done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL fault_recheck done=%b err=%b exp done=1 err=0", done, err); end
    step();
  endtask

  // Reset asserted during the 2nd APPLY cycle of TOGGLE x5
  task automatic test_reset_mid();
    int done_before;
    issue(2'b11, 4'b1111, 4'd5);
    step();
    checks++; if (busy !== 1'b1 || j !== 4'b1111) begin
      errors++; $display("FAIL rmid_apply2 busy=%b j=%b exp busy=1 j=1111", busy, j); end
    done_before = done_seen;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (j !== 4'b0000 || k !== 4'b0000 || busy !== 1'b0 || exp_q !== 4'b0000 || cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rmid_reset j=%b k=%b busy=%b expq=%b rdy=%b done=%b err=%b exp all 0 rdy=1", j, k, busy, exp_q, cmd_ready, done, err); end
    for (int c = 0; c < 10; c++) step();
    checks++; if (done_seen !== done_before) begin
      errors++; $display("FAIL rmid_no_done got=%0d exp=%0d", done_seen, done_before); end
  endtask

  // cmd_valid held with two queued commands: SET 0001 x2, then CLR 0001 x1
  task automatic test_back_to_back();
    int acc0;
    acc0 = accepts;
    cmd_op = 2'b01; cmd_mask = 4'b0001; cmd_reps = 4'd2; cmd_valid = 1'b1;
    step();
    cmd_op = 2'b10; cmd_mask = 4'b0001; cmd_reps = 4'd1;
    for (int c = 1; c <= 3; c++) begin
      checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0 || accepts !== acc0 + 1) begin
        errors++; $display("FAIL b2b_busy c%0d busy=%b rdy=%b acc=%0d exp busy=1 rdy=0 acc=%0d", c, busy, cmd_ready, accepts, acc0 + 1); end
      checks++; if (c <= 2 && (j !== 4'b0001 || k !== 4'b0000)) begin
        errors++; $display("FAIL b2b_apply1 c%0d j=%b k=%b exp j=0001 k=0000", c, j, k); end
      step();
    end
    checks++; if (done !== 1'b1 || cmd_ready !== 1'b1 || exp_q !== 4'b0001) begin
      errors++; $display("FAIL b2b_done1 done=%b rdy=%b expq=%b exp done=1 rdy=1 expq=0001", done, cmd_ready, exp_q); end
    step();
    cmd_valid = 1'b0;
    checks++; if (accepts !== acc0 + 2 || done !== 1'b0 || j !== 4'b0000 || k !== 4'b0001 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept2 acc=%0d done=%b j=%b k=%b busy=%b exp acc=%0d done=0 j=0 k=0001 busy=1", accepts, done, j, k, busy, acc0 + 2); end
    step(); step();
    checks++; if (done !== 1'b1 || exp_q !== 4'b0000 || err !== 1'b0 || accepts !== acc0 + 2) begin
      errors++; $display("FAIL b2b_done2 done=%b expq=%b err=%b acc=%0d exp done=1 expq=0000 err=0 acc=%0d", done, exp_q, err, accepts, acc0 + 2); end
    step();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_mask = 4'b0000; cmd_reps = 4'd0;
    stuck0 = 4'b0000;
    step(); step();
    rst = 1'b0;
    test_reset();
    test_set();
    test_toggle();
    test_clr_hold();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jkff_bank_seq.md
# jkff_bank_seq

Command-driven sequencer for a bank of `WIDTH` external `jkff` instances. It accepts one command at a time over a valid/ready handshake (SET, CLR, TOGGLE or HOLD, with a bit mask and a repeat count) and drives the bank's J/K vectors for the requested number of clocks. It keeps a reference model of the expected bank state, then compares the bank's Q outputs against that model and reports pass/fail. It sits between a test/config master and the JK flop bank, and is the only driver of the bank's `j`/`k` inputs.

## Interface
Parameters:
- `WIDTH`, default 4: number of JK flops in the bank.
- `CNT_W`, default 4: width of the repeat count; max repeats is 2^CNT_W-1.

Ports:
- `clk` in 1: single clock, rising edge; all state changes on this edge.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command; high exactly when state is IDLE.
- `cmd_op` in 2: 00 HOLD, 01 SET, 10 CLR, 11 TOGGLE.
- `cmd_mask` in WIDTH: bits affected by the op.
- `cmd_reps` in CNT_W: number of apply cycles.
- `j` out WIDTH: J vector to the bank.
- `k` out WIDTH: K vector to the bank.
- `q` in WIDTH: Q vector from the bank.
- `busy` out 1: high in APPLY or CHECK.
- `done` out 1: one-cycle pulse at completion.
- `err` out 1: sticky mismatch flag.
- `exp_q` out WIDTH: current reference-model value.

## Operation
- States: IDLE, APPLY, CHECK.
- Handshake: a command is accepted at a rising edge with `cmd_valid && cmd_ready`. `cmd_*` are ignored at all other times.
- On accept:
  - latch op, mask and reps;
  - load `exp_q <= q`;
  - clear `err`;
  - go to APPLY if reps != 0, else go to CHECK.
- J/K encoding, on masked bits only, during APPLY:
  - SET: j=mask, k=0.
  - CLR: j=0, k=mask.
  - TOGGLE: j=mask, k=mask.
  - HOLD: j=0, k=0.
- Unmasked bits always have j=k=0. In IDLE and CHECK, j=k=0 on all bits.
- `j`/`k` are registered outputs, valid for the whole APPLY cycle.
- Each APPLY edge updates the model the same way the bank updates:
  - SET: `exp_q |= mask`.
  - CLR: `exp_q &= ~mask`.
  - TOGGLE: `exp_q ^= mask`.
  - HOLD: no change.
- The remaining-count register decrements on each APPLY edge. The last APPLY goes to CHECK.
- CHECK lasts one cycle; `q` then reflects the final apply edge. At the closing edge:
  - `err <= (q != exp_q)`;
  - `done <= 1`;
  - state <= IDLE.
- `err` holds until the next accepted command or reset.
- Arithmetic: remaining count is CNT_W bits and never wraps (stops at the transition to CHECK). `exp_q` is a bitwise op only.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `j`=0, `k`=0, `busy`=0, `done`=0, `err`=0, `exp_q`=0.
- Latency, with acceptance edge A:
  - APPLY occupies cycles 1..reps after A;
  - CHECK is cycle reps+1;
  - `done`=1 and `cmd_ready`=1 in cycle reps+2.
  - reps=0 therefore gives `done` two cycles after A.
- Back-to-back: a new command may be accepted at the edge ending the `done` cycle. `done` is not extended.
- Reset mid-operation (APPLY or CHECK):
  - next cycle all outputs take reset values;
  - no `done` pulse;
  - the partial command is discarded.
- `cmd_valid` asserted during busy: not accepted, no side effect.
- `q` changing outside CHECK: ignored, except for the load at accept.

## Test plan
- Reset, bank q=0000 -> SET mask=0101 reps=1: `j`=0101, `k`=0000 for exactly one cycle; `done` in cycle 3 after accept; `exp_q`=0101; `err`=0.
- From 0101, TOGGLE mask=1111 reps=3: three cycles of `j`=`k`=1111; final `exp_q`=1010, `q`=1010, `err`=0, `done` at cycle 5.
- From 1010, CLR mask=1000 reps=2, then HOLD mask=1111 reps=0: `exp_q`=0010 after the first command; the second gives `done` at cycle 2, `err`=0, and j=k=0 throughout.
- Fault injection: the bench forces bank q bit0 stuck at 0 and issues SET mask=0001 reps=1 -> `err`=1 after CHECK. The next accepted command clears `err` to 0.
- Assert `rst` in the 2nd APPLY cycle of TOGGLE reps=5: next cycle `j`=`k`=0, `busy`=0, `exp_q`=0, `cmd_ready`=1, and no `done` pulse ever appears.
- Hold `cmd_valid`=1 with two queued commands: the second is accepted at the edge ending the first command's `done` cycle; no command is accepted while `busy`=1.
